nanorv32_wbstage: RTL and testbench



---
 rtl/nanorv32_wbstage_pkg.sv | 28 ++
 rtl/nanorv32_load_align.sv | 40 ++++
 rtl/nanorv32_wbstage.sv | 115 +++++++++++
 tb/tb_nanorv32_wbstage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_wbstage_pkg.sv
// Shared write-back definitions: data/select widths, load funct3 codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nanorv32_wbstage_pkg;

   localparam int NANORV32_DATA_MSB      = 31;
   localparam int NANORV32_RF_PORTRD_MSB = 4;

   // Load size/sign encodings carried in funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } wb_state_e;

   // Everything about an accepted load needed to finish it when data returns
   typedef struct packed {
      logic [NANORV32_RF_PORTRD_MSB:0] sel;
      logic [2:0]                      funct3;
      logic [1:0]                      lsb;
   } load_ctx_t;

endpackage

// File: rtl/nanorv32_load_align.sv
// Extracts, aligns and sign/zero-extends a load from the raw memory word; flags bad loads.
// Latency: combinational.
// Backpressure: none.
module nanorv32_load_align
   import nanorv32_wbstage_pkg::*;
(
   input  logic [NANORV32_DATA_MSB:0] rdata,
   input  logic [2:0]                 funct3,
   input  logic [1:0]                 lsb,
   output logic [NANORV32_DATA_MSB:0] data,
   output logic                       err
);

   logic [NANORV32_DATA_MSB:0] shifted;

   // Bring the addressed byte down to bit 0, then extend according to size/sign
   always_comb begin
      shifted = rdata >> {lsb, 3'b000};
      data    = shifted;
      err     = 1'b0;
      unique case (funct3)
         F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU: data = {24'h0, shifted[7:0]};
         F3_LH: begin
            data = {{16{shifted[15]}}, shifted[15:0]};
            err  = lsb[0];
         end
         F3_LHU: begin
            data = {16'h0, shifted[15:0]};
            err  = lsb[0];
         end
         F3_LW: begin
            data = rdata;
            err  = (lsb != 2'b00);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/nanorv32_wbstage.sv
// Write-back stage: registers ALU results, waits for and aligns load data, drives the RF write port.
// Latency: ALU result 1 cycle after accept; load data 1 cycle after dmem_rvalid.
// Backpressure: ex_ready is low for the whole time a load is outstanding.
module nanorv32_wbstage
   import nanorv32_wbstage_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            ex_valid,
   output logic                            ex_ready,
   input  logic [NANORV32_RF_PORTRD_MSB:0] ex_sel_rd,
   input  logic [NANORV32_DATA_MSB:0]      ex_result,
   input  logic                            ex_is_load,
   input  logic [2:0]                      ex_funct3,
   input  logic [1:0]                      ex_addr_lsb,
   input  logic                            dmem_rvalid,
   input  logic [NANORV32_DATA_MSB:0]      dmem_rdata,
   output logic [NANORV32_RF_PORTRD_MSB:0] sel_rd,
   output logic [NANORV32_DATA_MSB:0]      rd,
   output logic                            write_rd,
   output logic                            pend_valid,
   output logic [NANORV32_RF_PORTRD_MSB:0] pend_sel,
   output logic                            load_err
);

   wb_state_e                       state_q, state_d;
   load_ctx_t                       ctx_q, ctx_d;
   logic [NANORV32_RF_PORTRD_MSB:0] sel_rd_q, sel_rd_d;
   logic [NANORV32_DATA_MSB:0]      rd_q, rd_d;
   logic                            write_rd_q, write_rd_d;
   logic                            load_err_q, load_err_d;

   logic [NANORV32_DATA_MSB:0]      align_data;
   logic                            align_err;

   nanorv32_load_align u_align (
      .rdata  (dmem_rdata),
      .funct3 (ctx_q.funct3),
      .lsb    (ctx_q.lsb),
      .data   (align_data),
      .err    (align_err)
   );

   // Next state, load context capture and RF write port values
   always_comb begin
      state_d    = state_q;
      ctx_d      = ctx_q;
      sel_rd_d   = sel_rd_q;
      rd_d       = rd_q;
      write_rd_d = 1'b0;
      load_err_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A response with nothing outstanding is dropped but reported
            if (dmem_rvalid) begin
               load_err_d = 1'b1;
            end
            if (ex_valid) begin
               if (ex_is_load) begin
                  ctx_d.sel    = ex_sel_rd;
                  ctx_d.funct3 = ex_funct3;
                  ctx_d.lsb    = ex_addr_lsb;
                  state_d      = ST_LOAD_WAIT;
               end else begin
                  sel_rd_d   = ex_sel_rd;
                  rd_d       = ex_result;
                  write_rd_d = (ex_sel_rd != '0);
               end
            end
         end
         ST_LOAD_WAIT: begin
            if (dmem_rvalid) begin
               state_d = ST_IDLE;
               // A bad load consumes its response but leaves the RF port untouched
               if (align_err) begin
                  load_err_d = 1'b1;
               end else begin
                  sel_rd_d   = ctx_q.sel;
                  rd_d       = align_data;
                  write_rd_d = (ctx_q.sel != '0);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, context and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ctx_q      <= '0;
         sel_rd_q   <= '0;
         rd_q       <= '0;
         write_rd_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctx_q      <= ctx_d;
         sel_rd_q   <= sel_rd_d;
         rd_q       <= rd_d;
         write_rd_q <= write_rd_d;
         load_err_q <= load_err_d;
      end
   end

   assign ex_ready   = (state_q == ST_IDLE);
   assign pend_valid = (state_q == ST_LOAD_WAIT);
   assign pend_sel   = pend_valid ? ctx_q.sel : '0;
   assign sel_rd     = sel_rd_q;
   assign rd         = rd_q;
   assign write_rd   = write_rd_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_nanorv32_wbstage.sv
// Bench for the write-back stage: behavioural model compared every cycle plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_nanorv32_wbstage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_sel_rd;
   logic [31:0] ex_result;
   logic        ex_is_load;
   logic [2:0]  ex_funct3;
   logic [1:0]  ex_addr_lsb;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  sel_rd;
   logic [31:0] rd;
   logic        write_rd;
   logic        pend_valid;
   logic [4:0]  pend_sel;
   logic        load_err;

   nanorv32_wbstage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_sel_rd   (ex_sel_rd),
      .ex_result   (ex_result),
      .ex_is_load  (ex_is_load),
      .ex_funct3   (ex_funct3),
      .ex_addr_lsb (ex_addr_lsb),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .sel_rd      (sel_rd),
      .rd          (rd),
      .write_rd    (write_rd),
      .pend_valid  (pend_valid),
      .pend_sel    (pend_sel),
      .load_err    (load_err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int rdy_low_cnt = 0;
   int err_cnt = 0;
   int wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_busy = 0;
   logic [4:0]  m_sel = '0;
   logic [2:0]  m_f3 = '0;
   int          m_lsb = 0;
   logic        e_write = 0;
   logic [4:0]  e_sel = '0;
   logic [31:0] e_rd = '0;
   logic        e_err = 0;

   function automatic bit m_legal(input logic [2:0] f3, input int lsb);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return (lsb % 2) == 0;
         3'b010:         return lsb == 0;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input int lsb);
      logic [7:0]  b [4];
      logic [15:0] h;
      for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
      h = (lsb < 3) ? {b[lsb+1], b[lsb]} : 16'h0;
      case (f3)
         3'b000:  return b[lsb][7] ? (32'hFFFFFF00 | 32'(b[lsb])) : 32'(b[lsb]);
         3'b100:  return 32'(b[lsb]);
         3'b001:  return h[15] ? (32'hFFFF0000 | 32'(h)) : 32'(h);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_sel = '0; m_f3 = '0; m_lsb = 0;
         e_write = 0; e_sel = '0; e_rd = '0; e_err = 0;
      end else begin
         logic nw, ne;
         nw = 0; ne = 0;
         if (!m_busy) begin
            if (dmem_rvalid) ne = 1;
            if (ex_valid) begin
               if (ex_is_load) begin
                  m_busy = 1; m_sel = ex_sel_rd; m_f3 = ex_funct3; m_lsb = int'(ex_addr_lsb);
               end else begin
                  e_sel = ex_sel_rd; e_rd = ex_result; nw = (ex_sel_rd != 0);
               end
            end
         end else if (dmem_rvalid) begin
            m_busy = 0;
            if (m_legal(m_f3, m_lsb)) begin
               e_rd = m_load(dmem_rdata, m_f3, m_lsb); e_sel = m_sel; nw = (m_sel != 0);
            end else begin
               ne = 1;
            end
         end
         e_write = nw;
         e_err   = ne;
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      check("write_rd",   32'(write_rd),   32'(e_write));
      check("sel_rd",     32'(sel_rd),     32'(e_sel));
      check("rd",         rd,              e_rd);
      check("load_err",   32'(load_err),   32'(e_err));
      check("ex_ready",   32'(ex_ready),   32'(!m_busy));
      check("pend_valid", 32'(pend_valid), 32'(m_busy));
      check("pend_sel",   32'(pend_sel),   m_busy ? 32'(m_sel) : 32'h0);
      if (!ex_ready) rdy_low_cnt++;
      if (load_err)  err_cnt++;
      if (write_rd)  wr_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] sel, input logic [2:0] f3, input logic [1:0] lsb,
                          input logic [31:0] data, input int waits);
      ex_valid = 1; ex_is_load = 1; ex_sel_rd = sel; ex_funct3 = f3; ex_addr_lsb = lsb;
      tick();
      ex_valid = 0; ex_is_load = 0;
      repeat (waits) tick();
      dmem_rvalid = 1; dmem_rdata = data;
      tick();
      dmem_rvalid = 0;
   endtask

   int snap_a, snap_b;

   initial begin
      rst_n = 1; ex_valid = 0; ex_sel_rd = '0; ex_result = '0; ex_is_load = 0;
      ex_funct3 = '0; ex_addr_lsb = '0; dmem_rvalid = 0; dmem_rdata = '0;
      #1 rst_n = 0;
      @(negedge clk);
      check("rst write_rd", 32'(write_rd), 32'h0);
      check("rst rd", rd, 32'h0);
      check("rst ex_ready", 32'(ex_ready), 32'h1);
      tick(); tick();
      rst_n = 1;
      tick();

      // ALU write
      ex_valid = 1; ex_sel_rd = 5'd5; ex_result = 32'hDEADBEEF;
      tick();
      ex_valid = 0;
      @(negedge clk);
      check("alu write_rd", 32'(write_rd), 32'h1);
      check("alu sel_rd", 32'(sel_rd), 32'd5);
      check("alu rd", rd, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      check("alu write_rd after", 32'(write_rd), 32'h0);
      tick();

      // x0 suppression
      snap_a = wr_cnt;
      ex_valid = 1; ex_sel_rd = 5'd0; ex_result = 32'h0000_1234;
      tick();
      ex_valid = 0;
      tick(); tick();
      check("x0 write count", 32'(wr_cnt - snap_a), 32'd0);

      // Back-to-back ALU at full rate
      snap_a = wr_cnt;
      for (int i = 1; i <= 4; i++) begin
         ex_valid = 1; ex_sel_rd = 5'(i); ex_result = 32'h11111111 * 32'(i);
         tick();
      end
      ex_valid = 0;
      tick();
      check("b2b write count", 32'(wr_cnt - snap_a), 32'd4);

      // LB sign extension, three wait cycles
      snap_a = rdy_low_cnt;
      ex_valid = 1; ex_is_load = 1; ex_sel_rd = 5'd7; ex_funct3 = 3'b000; ex_addr_lsb = 2'd3;
      tick();
      ex_valid = 0; ex_is_load = 0;
      tick();
      @(negedge clk);
      check("lb pend_valid", 32'(pend_valid), 32'h1);
      check("lb pend_sel", 32'(pend_sel), 32'd7);
      tick(); tick();
      dmem_rvalid = 1; dmem_rdata = 32'h80112233;
      tick();
      dmem_rvalid = 0;
      @(negedge clk);
      check("lb rd", rd, 32'hFFFFFF80);
      check("lb write_rd", 32'(write_rd), 32'h1);
      check("lb sel_rd", 32'(sel_rd), 32'd7);
      check("lb ex_ready back", 32'(ex_ready), 32'h1);
      tick();
      check("lb ready-low cycles", 32'(rdy_low_cnt - snap_a), 32'd4);

      // LHU, immediate response
      do_load(5'd9, 3'b101, 2'd2, 32'hBEEF1234, 0);
      @(negedge clk);
      check("lhu rd", rd, 32'h0000BEEF);
      tick();

      // LW
      do_load(5'd10, 3'b010, 2'd0, 32'h12345678, 1);
      @(negedge clk);
      check("lw rd", rd, 32'h12345678);
      tick();

      // LH sign extension
      do_load(5'd11, 3'b001, 2'd0, 32'h00008001, 2);
      @(negedge clk);
      check("lh rd", rd, 32'hFFFF8001);
      tick();

      // Misaligned LW, then unsolicited response in IDLE
      snap_a = err_cnt; snap_b = wr_cnt;
      do_load(5'd12, 3'b010, 2'd1, 32'hAAAA5555, 1);
      dmem_rvalid = 1; dmem_rdata = 32'h0BAD0BAD;
      tick();
      dmem_rvalid = 0;
      tick(); tick();
      check("misalign err pulses", 32'(err_cnt - snap_a), 32'd2);
      check("misalign writes", 32'(wr_cnt - snap_b), 32'd0);

      // Illegal funct3 and load to x0 (model-checked)
      do_load(5'd13, 3'b011, 2'd0, 32'hCAFEF00D, 0);
      tick();
      do_load(5'd0, 3'b010, 2'd0, 32'hCAFEF00D, 1);
      tick();

      // Reset while a load is outstanding
      ex_valid = 1; ex_is_load = 1; ex_sel_rd = 5'd14; ex_funct3 = 3'b010; ex_addr_lsb = 2'd0;
      tick();
      ex_valid = 0; ex_is_load = 0;
      tick();
      rst_n = 0;
      @(negedge clk);
      check("midrst pend_valid", 32'(pend_valid), 32'h0);
      check("midrst rd", rd, 32'h0);
      check("midrst sel_rd", 32'(sel_rd), 32'h0);
      check("midrst ex_ready", 32'(ex_ready), 32'h1);
      tick();
      rst_n = 1;
      snap_a = err_cnt;
      dmem_rvalid = 1; dmem_rdata = 32'h55555555;
      tick();
      dmem_rvalid = 0;
      @(negedge clk);
      check("midrst load_err", 32'(load_err), 32'h1);
      check("midrst write_rd", 32'(write_rd), 32'h0);
      tick();
      check("midrst err pulses", 32'(err_cnt - snap_a), 32'd1);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
